reg_snapshot_streamer: RTL and testbench

- Hardware producer of per-cycle processor state dumps: cycle stamp, PC, and the 18 programmer-visible registers $s0-$s7 and $t0-$t9.
- Samples the register file through a debug read port.
- Streams the dump as tagged 32-bit beats over a valid/ready interface to a host-side consumer (trace logger, UART bridge, or bench monitor).
- Sits beside the pipeline top level and is triggered by a snapshot request pulse.

---
 rtl/reg_snapshot_streamer.sv | 139 +++++++++++++
 tb/tb_reg_snapshot_streamer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_snapshot_streamer.sv
// Streams a 20-beat processor state dump (cycle stamp, PC, $s0-$s7, $t0-$t9) per snap_req.
// First beat visible one cycle after the request; a single output register holds under out_ready backpressure.
module reg_snapshot_streamer #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              snap_req,
   input  logic [DATA_W-1:0] pc_in,
   output logic [4:0]        dbg_raddr,
   input  logic [DATA_W-1:0] dbg_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_tag,
   output logic [4:0]        out_idx,
   output logic              out_last,
   output logic              busy,
   output logic [7:0]        drop_cnt
);

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t            r_state,  w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [4:0]        r_k,      w_k_nxt;
   logic [DATA_W-1:0] r_pc,     w_pc_nxt;
   logic              r_vld,    w_vld_nxt;
   logic [DATA_W-1:0] r_dat,    w_dat_nxt;
   logic [1:0]        r_tag,    w_tag_nxt;
   logic [4:0]        r_idx,    w_idx_nxt;
   logic              r_last,   w_last_nxt;
   logic [7:0]        r_drop,   w_drop_nxt;
   logic [4:0]        w_beat_k;
   logic [4:0]        w_raddr;

   // Beat k (2..19) -> register number: $s0-$s7, then $t0-$t7, then $t8-$t9.
   function automatic logic [4:0] reg_of(input logic [4:0] k);
      logic [4:0] j;
      j = k - 5'd2;
      if (j < 5'd8)       return j + 5'd16;
      else if (j < 5'd16) return j;
      else                return j + 5'd8;
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      w_pc_nxt    = r_pc;
      w_vld_nxt   = r_vld;
      w_dat_nxt   = r_dat;
      w_tag_nxt   = r_tag;
      w_idx_nxt   = r_idx;
      w_last_nxt  = r_last;
      w_beat_k    = r_k + 5'd1;
      w_raddr     = 5'd0;
      case (r_state)
         S_IDLE: begin
            if (snap_req) begin
               w_state_nxt = S_STREAM;
               w_k_nxt     = 5'd0;
               w_pc_nxt    = pc_in;
               w_vld_nxt   = 1'b1;
               w_dat_nxt   = DATA_W'(r_cnt);
               w_tag_nxt   = 2'd0;
               w_idx_nxt   = 5'd0;
               w_last_nxt  = 1'b0;
            end
         end
         S_STREAM: begin
            // Address the register of the beat loaded next, so read data is ready at that edge.
            if (w_beat_k >= 5'd2 && w_beat_k <= 5'd19) w_raddr = reg_of(w_beat_k);
            if (r_vld && out_ready) begin
               if (r_k == 5'd19) begin
                  w_state_nxt = S_IDLE;
                  w_vld_nxt   = 1'b0;
                  w_last_nxt  = 1'b0;
               end else begin
                  w_k_nxt    = w_beat_k;
                  w_vld_nxt  = 1'b1;
                  w_last_nxt = (w_beat_k == 5'd19);
                  if (w_beat_k == 5'd1) begin
                     w_dat_nxt = r_pc;
                     w_tag_nxt = 2'd1;
                     w_idx_nxt = 5'd0;
                  end else begin
                     w_dat_nxt = dbg_rdata;
                     w_tag_nxt = 2'd2;
                     w_idx_nxt = w_raddr;
                  end
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_drop_nxt = r_drop;
      if (snap_req && (r_state == S_STREAM) && (r_drop != 8'hFF)) w_drop_nxt = r_drop + 8'd1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_k     <= 5'd0;
         r_pc    <= '0;
         r_vld   <= 1'b0;
         r_dat   <= '0;
         r_tag   <= 2'd0;
         r_idx   <= 5'd0;
         r_last  <= 1'b0;
         r_drop  <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= r_cnt + 1'b1;
         r_k     <= w_k_nxt;
         r_pc    <= w_pc_nxt;
         r_vld   <= w_vld_nxt;
         r_dat   <= w_dat_nxt;
         r_tag   <= w_tag_nxt;
         r_idx   <= w_idx_nxt;
         r_last  <= w_last_nxt;
         r_drop  <= w_drop_nxt;
      end
   end

   assign dbg_raddr = w_raddr;
   assign out_valid = r_vld;
   assign out_data  = r_dat;
   assign out_tag   = r_tag;
   assign out_idx   = r_idx;
   assign out_last  = r_last;
   assign busy      = (r_state == S_STREAM);
   assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_reg_snapshot_streamer.sv
// Directed bench for reg_snapshot_streamer: reset, dumps, backpressure, drops, counter wrap, mid-stream reset.
module tb_reg_snapshot_streamer;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        snap_req = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] pc_in = 32'h0;
   logic [4:0]  dbg_raddr;
   logic [31:0] dbg_rdata;
   logic        out_valid;
   logic [31:0] out_data;
   logic [1:0]  out_tag;
   logic [4:0]  out_idx;
   logic        out_last;
   logic        busy;
   logic [7:0]  drop_cnt;

   logic [31:0] rf [32];
   int          order [18] = '{16, 17, 18, 19, 20, 21, 22, 23, 8, 9, 10, 11, 12, 13, 14, 15, 24, 25};
   logic        rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   int          cyc;
   int          n_chk = 0;
   int          n_fail = 0;

   assign dbg_rdata = rf[dbg_raddr];

   reg_snapshot_streamer #(.DATA_W(32), .CNT_W(8)) dut (
      .clock(clock), .reset_n(reset_n), .snap_req(snap_req), .pc_in(pc_in),
      .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag), .out_idx(out_idx), .out_last(out_last),
      .busy(busy), .drop_cnt(drop_cnt)
   );

   always #5 clock = ~clock;

   // Edges since reset release; equals the DUT cycle counter before the next edge.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_vld"},  out_valid, 0);
      chk({tag, "_dat"},  out_data, 0);
      chk({tag, "_tag"},  out_tag, 0);
      chk({tag, "_idx"},  out_idx, 0);
      chk({tag, "_last"}, out_last, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_drop"}, drop_cnt, 0);
      chk({tag, "_ra"},   dbg_raddr, 0);
   endtask

   // Called at a negedge; the following edge is the trigger edge.
   task automatic trigger(output logic [31:0] stamp);
      snap_req = 1'b1;
      stamp = 32'(cyc & 255);
      @(negedge clock);
      snap_req = 1'b0;
   endtask

   // Consumes beats from a negedge with beat 0 on the output; mode 0 = always ready, 1 = 1,0,0,1 pattern.
   task automatic collect(input int mode, input logic [31:0] stamp, input logic [31:0] pc,
                          input int nbeats, output int used);
      int n, k;
      logic stall;
      logic [31:0] h_dat, e_dat;
      logic [1:0]  h_tag, e_tag;
      logic [4:0]  h_idx, h_ra, e_idx, e_ra;
      logic        h_last;
      n = 0; used = 0; stall = 1'b0;
      h_dat = 0; h_tag = 0; h_idx = 0; h_ra = 0; h_last = 0;
      while (n < nbeats && used < 400) begin
         out_ready = (mode == 0) ? 1'b1 : rdy_pat[used % 4];
         if (stall) begin
            chk("hold_dat", out_data, h_dat);
            chk("hold_tag", out_tag, h_tag);
            chk("hold_idx", out_idx, h_idx);
            chk("hold_last", out_last, h_last);
            chk("hold_ra", dbg_raddr, h_ra);
         end
         chk("stream_vld", out_valid, 1);
         k = n + 1;
         e_ra = (k >= 2 && k <= 19) ? 5'(order[k-2]) : 5'd0;
         chk("next_ra", dbg_raddr, e_ra);
         if (out_valid && out_ready) begin
            if (n == 0)      begin e_tag = 0; e_dat = stamp; e_idx = 0; end
            else if (n == 1) begin e_tag = 1; e_dat = pc;    e_idx = 0; end
            else begin e_tag = 2; e_idx = 5'(order[n-2]); e_dat = rf[order[n-2]]; end
            chk("beat_tag", out_tag, e_tag);
            chk("beat_dat", out_data, e_dat);
            chk("beat_idx", out_idx, e_idx);
            chk("beat_last", out_last, (n == 19));
            n++;
            stall = 1'b0;
         end else begin
            stall = 1'b1;
            h_dat = out_data; h_tag = out_tag; h_idx = out_idx; h_last = out_last; h_ra = dbg_raddr;
         end
         used++;
         @(negedge clock);
      end
      chk("beat_count", n, nbeats);
   endtask

   task automatic chk_idle_after(input string tag);
      chk({tag, "_vld"},  out_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_last"}, out_last, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog checks=%0d", n_chk);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] stamp;
      int used;
      int guard;
      for (int i = 0; i < 32; i++) rf[i] = 32'(i);

      // Reset state
      #3;
      chk_all_zero("rst");
      @(negedge clock);
      reset_n = 1'b1;
      out_ready = 1'b1;
      guard = 0;
      while (cyc != 5 && guard < 20) begin
         chk("pre_vld", out_valid, 0);
         @(negedge clock);
         guard++;
      end

      // Single dump, always ready, stamp 5
      pc_in = 32'h0040_0020;
      trigger(stamp);
      collect(0, 32'h5, 32'h0040_0020, 20, used);
      chk("consec_cycles", used, 20);
      chk_idle_after("dump1_end");

      // Idle with out_ready high: no beats
      out_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         chk("idle_vld", out_valid, 0);
      end

      // Backpressure with fresh register values
      for (int i = 0; i < 32; i++) rf[i] = 32'hC0DE_0000 + 32'(i * 32'h111);
      pc_in = 32'h1234_5678;
      trigger(stamp);
      collect(1, stamp, 32'h1234_5678, 20, used);
      chk_idle_after("bp_end");

      // Counter wrap: stamps 0xFF and 0x2C
      guard = 0;
      while (cyc != 255 && guard < 400) begin @(negedge clock); guard++; end
      trigger(stamp);
      collect(0, 32'hFF, 32'h1234_5678, 20, used);
      guard = 0;
      while (cyc != 300 && guard < 400) begin @(negedge clock); guard++; end
      pc_in = 32'hDEAD_BEE0;
      trigger(stamp);
      collect(0, 32'h2C, 32'hDEAD_BEE0, 20, used);
      chk_idle_after("wrap_end");

      // Drop: snap_req held across a snapshot and into the next IDLE edge
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      out_ready = 1'b1;
      pc_in = 32'h0000_0A00;
      snap_req = 1'b1;
      for (int i = 1; i <= 21; i++) @(negedge clock);
      chk("drop_cnt", drop_cnt, 20);
      chk("drop_gap_vld", out_valid, 0);
      chk("drop_gap_busy", busy, 0);
      stamp = 32'(cyc & 255);
      @(negedge clock);
      snap_req = 1'b0;
      chk("drop_restart_busy", busy, 1);
      collect(0, stamp, 32'h0000_0A00, 20, used);
      chk("drop_cnt_after", drop_cnt, 20);

      // Reset mid-stream after beat 7 accepted
      pc_in = 32'h0000_7700;
      trigger(stamp);
      collect(0, stamp, 32'h0000_7700, 8, used);
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1 chk_all_zero("rst_mid");
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      chk("rst_mid_quiet", out_valid, 0);
      pc_in = 32'h0000_8800;
      trigger(stamp);
      collect(0, stamp, 32'h0000_8800, 20, used);
      chk_idle_after("rst_mid_end");

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
